grid_redraw_ctrl: RTL and testbench

GRID_REDRAW_CTRL -- requirements
Module: grid_redraw_ctrl

---
 rtl/grid_redraw_ctrl.sv | 179 +++++++++++++++++
 tb/tb_grid_redraw_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_redraw_ctrl.sv
// Purpose : incremental 4x4 tile redraw sequencer driving an external glyph lookup and a VGA plot port.
// Latency : 1 cycle from glyph_* coordinates to the matching plot/x/y/colour; 1 SCAN cycle per tile, 225 DRAW cycles per dirty tile.
// Backpressure: none; a start while busy is remembered once and replayed after the current run finishes.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   start, force_full   - redraw request; force_full makes every tile dirty for that run
//   values              - 16 x 4-bit tile exponents, tile k at values[4k+3:4k]
//   glyph_value/x/y     - tile exponent and tile-local pixel to the glyph lookup
//   pix_colour          - combinational colour returned by the glyph lookup
//   x, y, colour, plot  - registered VGA write port
//   busy, done          - run in progress / 1-cycle end-of-run pulse
module grid_redraw_ctrl #(
    parameter int ORIGIN_X = 57,
    parameter int ORIGIN_Y = 27,
    parameter int PITCH    = 17,
    parameter int TILE     = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        force_full,
    input  logic [63:0] values,
    output logic [3:0]  glyph_value,
    output logic [3:0]  glyph_x,
    output logic [3:0]  glyph_y,
    input  logic [2:0]  pix_colour,
    output logic [6:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAW,
        S_FINISH
    } state_t;

    localparam logic [3:0] TILE_LAST = 4'(TILE - 1);

    state_t      state_q;
    logic [63:0] snap_q;
    logic [63:0] shown_q;
    logic        valid_q;
    logic        full_q;
    logic        pending_q;
    logic [3:0]  t_q;
    logic [3:0]  gx_q;
    logic [3:0]  gy_q;
    logic [6:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  colour_q;
    logic        plot_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  snap_nib;
    logic [3:0]  shown_nib;
    logic        dirty;
    logic [6:0]  px_d;
    logic [6:0]  py_d;

    assign snap_nib  = snap_q[{t_q, 2'b00} +: 4];
    assign shown_nib = shown_q[{t_q, 2'b00} +: 4];
    assign dirty     = full_q | (snap_nib != shown_nib);

    // Column is t mod 4, row is t div 4; defaults keep the sum below 128.
    assign px_d = 7'(ORIGIN_X + PITCH * int'(t_q[1:0]) + int'(gx_q));
    assign py_d = 7'(ORIGIN_Y + PITCH * int'(t_q[3:2]) + int'(gy_q));

    // Glyph request is only meaningful while drawing; held at 0 otherwise.
    assign glyph_value = (state_q == S_DRAW) ? snap_nib : 4'd0;
    assign glyph_x     = (state_q == S_DRAW) ? gx_q     : 4'd0;
    assign glyph_y     = (state_q == S_DRAW) ? gy_q     : 4'd0;

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            shown_q   <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            pending_q <= 1'b0;
            t_q       <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_q  <= values;
                        // Until one run has completed, the screen content is unknown.
                        full_q  <= force_full | ~valid_q;
                        t_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (start) pending_q <= 1'b1;
                    if (dirty) begin
                        gx_q    <= '0;
                        gy_q    <= '0;
                        state_q <= S_DRAW;
                    end else if (t_q != 4'd15) begin
                        t_q <= t_q + 4'd1;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_DRAW: begin
                    if (start) pending_q <= 1'b1;
                    plot_q   <= 1'b1;
                    x_q      <= px_d;
                    y_q      <= py_d;
                    colour_q <= pix_colour;
                    if (gx_q == TILE_LAST) begin
                        gx_q <= '0;
                        if (gy_q == TILE_LAST) begin
                            gy_q <= '0;
                            shown_q[{t_q, 2'b00} +: 4] <= snap_nib;
                            if (t_q != 4'd15) begin
                                t_q     <= t_q + 4'd1;
                                state_q <= S_SCAN;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_FINISH;
                            end
                        end else begin
                            gy_q <= gy_q + 4'd1;
                        end
                    end else begin
                        gx_q <= gx_q + 4'd1;
                    end
                end
                S_FINISH: begin
                    valid_q <= 1'b1;
                    // A start arriving in this very cycle is treated like a pending one,
                    // otherwise it would be lost on the way back to IDLE.
                    if (pending_q | start) begin
                        snap_q    <= values;
                        full_q    <= force_full;
                        t_q       <= '0;
                        pending_q <= 1'b0;
                        state_q   <= S_SCAN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_redraw_ctrl.sv
// Purpose : randomized scoreboard bench for grid_redraw_ctrl against a run-level reference model.
// Latency : model predicts each run's pixel list at start acceptance and its length as 16 + 225*dirty cycles plus FINISH.
// Backpressure: n/a; monitor pops one expected pixel per observed plot.
module tb_grid_redraw_ctrl;

    localparam int OX = 57;
    localparam int OY = 27;
    localparam int PT = 17;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        force_full = 1'b0;
    logic [63:0] values = '0;
    logic [3:0]  glyph_value, glyph_x, glyph_y;
    logic [2:0]  pix_colour;
    logic [6:0]  x, y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    always #5 clock = ~clock;

    grid_redraw_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .force_full  (force_full),
        .values      (values),
        .glyph_value (glyph_value),
        .glyph_x     (glyph_x),
        .glyph_y     (glyph_y),
        .pix_colour  (pix_colour),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    function automatic logic [2:0] colour_fn(input logic [3:0] v, input logic [3:0] gx, input logic [3:0] gy);
        logic [5:0] s;
        s = {2'b00, v} + {2'b00, gx} + {1'b0, gy, 1'b0};
        return s[2:0];
    endfunction

    assign pix_colour = colour_fn(glyph_value, glyph_x, glyph_y);

    typedef struct packed {
        logic [6:0] px;
        logic [6:0] py;
        logic [3:0] v;
        logic [3:0] gx;
        logic [3:0] gy;
    } pix_t;

    pix_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model (run level) ----------------
    bit         m_busy  = 1'b0;
    bit         m_pend  = 1'b0;
    bit         m_valid = 1'b0;
    int         m_rem   = 0;
    int         m_run_plots = 0;
    logic [3:0] m_shown[16];
    bit         exp_busy = 1'b0;
    bit         exp_done = 1'b0;

    task automatic start_run(input logic [63:0] v, input bit full);
        int n;
        logic [3:0] nib;
        pix_t p;
        n = 0;
        for (int t = 0; t < 16; t++) begin
            nib = v[4*t +: 4];
            if (full || nib != m_shown[t]) begin
                n++;
                m_shown[t] = nib;
                for (int gy = 0; gy < 15; gy++) begin
                    for (int gx = 0; gx < 15; gx++) begin
                        p.px = 7'(OX + PT * (t % 4) + gx);
                        p.py = 7'(OY + PT * (t / 4) + gy);
                        p.v  = nib;
                        p.gx = 4'(gx);
                        p.gy = 4'(gy);
                        exp_q.push_back(p);
                    end
                end
            end
        end
        m_rem       = 16 + 225 * n;
        m_run_plots = 225 * n;
        m_busy      = 1'b1;
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_pend  = 1'b0;
            m_valid = 1'b0;
            m_rem   = 0;
            for (int t = 0; t < 16; t++) m_shown[t] = 4'd0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (start) start_run(values, force_full || !m_valid);
        end else if (m_rem > 0) begin
            m_rem--;
            if (start) m_pend = 1'b1;
        end else begin
            m_valid = 1'b1;
            if (m_pend || start) begin
                m_pend = 1'b0;
                start_run(values, force_full);
            end else begin
                m_busy = 1'b0;
            end
        end
        exp_busy = m_busy;
        exp_done = m_busy && (m_rem == 0);
    end

    // ---------------- monitor ----------------
    bit         mon_en = 1'b0;
    int         run_plots = 0;
    logic [3:0] pgv = '0, pgx = '0, pgy = '0;

    always @(negedge clock) begin
        pix_t e;
        if (mon_en) begin
            if (plot) begin
                if (exp_q.size() == 0) begin
                    check("plot_unexpected", 64'(plot), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 64'({x, y, colour, pgv, pgx, pgy}),
                          64'({e.px, e.py, colour_fn(e.v, e.gx, e.gy), e.v, e.gx, e.gy}));
                    run_plots++;
                end
            end
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            if (done) begin
                check("queue_empty_at_done", 64'(exp_q.size()), 64'(0));
                check("plots_per_run", 64'(run_plots), 64'(m_run_plots));
            end
            if (done || !busy) run_plots = 0;
        end
        pgv = glyph_value;
        pgx = glyph_x;
        pgy = glyph_y;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input bit ff);
        @(negedge clock);
        start      = 1'b1;
        force_full = ff;
        @(negedge clock);
        start      = 1'b0;
        force_full = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while ((busy || m_busy) && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        if (cycles >= budget) check("idle_within_budget", 64'(cycles), 64'(0));
    endtask

    initial begin
        int c;
        int k;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_outputs", 64'({x, y, colour, plot, busy, done, glyph_value, glyph_x, glyph_y}), 64'(0));
        mon_en = 1'b1;

        // First run after reset is full even with all-zero values.
        pulse_start(1'b0);
        wait_idle(5000, c);
        check("full_run_busy_cycles", 64'(c), 64'(3617));

        // Identical values, nothing dirty.
        pulse_start(1'b0);
        wait_idle(100, c);
        check("clean_run_busy_cycles", 64'(c), 64'(17));

        // Only tile 6 changes.
        values[27:24] = 4'h3;
        pulse_start(1'b0);
        wait_idle(1000, c);
        check("tile6_run_busy_cycles", 64'(c), 64'(242));

        // Mid-run start with changed values; later value changes must not leak into the run.
        values = {$urandom, $urandom};
        pulse_start(1'b1);
        repeat (400) @(negedge clock);
        values = {$urandom, $urandom};
        pulse_start(1'b0);
        repeat (200) @(negedge clock);
        values[15:0] = 16'(~values[15:0]);
        wait_idle(9000, c);
        check("pending_cleared", 64'({busy, dut.pending_q}), 64'(0));

        // Reset in the middle of drawing pixel 100.
        pulse_start(1'b1);
        c = 0;
        while (run_plots < 100 && c < 2000) begin
            @(negedge clock);
            c++;
        end
        check("reached_pixel_100", 64'(run_plots >= 100), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_plot_busy", 64'({plot, busy, done}), 64'(0));
        repeat (5) @(negedge clock);
        check("abort_stays_quiet", 64'({plot, busy, done}), 64'(0));
        pulse_start(1'b0);
        wait_idle(5000, c);
        check("post_reset_full_run", 64'(c), 64'(3617));

        // Randomized incremental runs.
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) values[4 * $urandom_range(0, 15) +: 4] = 4'($urandom);
            pulse_start($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 40)) @(negedge clock);
                values[4 * $urandom_range(0, 15) +: 4] = 4'($urandom);
                if (busy) pulse_start(1'b0);
            end
            wait_idle(9000, c);
        end

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
